// File: rtl/conv_window_buffer.sv
// 3x3 sliding-window generator for a raster pixel stream, built from two line buffers.
// Feeds a 3x3 convolution stage directly (win0 = top-left, win8 = newest pixel).
module conv_window_buffer #(
  parameter int unsigned DATA_W     = 12,
  parameter int unsigned IMG_WIDTH  = 640,
  parameter int unsigned IMG_HEIGHT = 480
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pix_in,
  input  logic              pix_valid,
  input  logic              sof,
  output logic [DATA_W-1:0] win0,
  output logic [DATA_W-1:0] win1,
  output logic [DATA_W-1:0] win2,
  output logic [DATA_W-1:0] win3,
  output logic [DATA_W-1:0] win4,
  output logic [DATA_W-1:0] win5,
  output logic [DATA_W-1:0] win6,
  output logic [DATA_W-1:0] win7,
  output logic [DATA_W-1:0] win8,
  output logic              win_valid,
  output logic              frame_done
);

  localparam int unsigned COL_W = $clog2(IMG_WIDTH);
  localparam int unsigned ROW_W = $clog2(IMG_HEIGHT);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

  logic [DATA_W-1:0] r_lb1 [IMG_WIDTH];
  logic [DATA_W-1:0] r_lb2 [IMG_WIDTH];
  logic [DATA_W-1:0] r_win [9];
  logic [DATA_W-1:0] r_out [9];
  logic [COL_W-1:0]  r_col;
  logic [ROW_W-1:0]  r_row;
  logic              r_win_valid;
  logic              r_frame_done;

  logic              w_sof;
  logic [COL_W-1:0]  w_col;
  logic [ROW_W-1:0]  w_row;
  logic [DATA_W-1:0] w_lb1;
  logic [DATA_W-1:0] w_lb2;
  logic [DATA_W-1:0] w_next [9];
  logic              w_win_ok;
  logic              w_last;

  // A qualified sof relocates the current pixel to (0,0) before any lookup,
  // so the partial frame's position never reaches the window or counters.
  always_comb begin
    w_sof    = pix_valid & sof;
    w_col    = w_sof ? '0 : r_col;
    w_row    = w_sof ? '0 : r_row;
    w_lb1    = r_lb1[w_col];
    w_lb2    = r_lb2[w_col];
    w_next[0] = r_win[1];
    w_next[1] = r_win[2];
    w_next[2] = w_lb2;
    w_next[3] = r_win[4];
    w_next[4] = r_win[5];
    w_next[5] = w_lb1;
    w_next[6] = r_win[7];
    w_next[7] = r_win[8];
    w_next[8] = pix_in;
    w_win_ok = (w_row >= ROW_W'(2)) && (w_col >= COL_W'(2));
    w_last   = (w_row == ROW_LAST) && (w_col == COL_LAST);
  end

  // Line buffers are never cleared; the position counters gate every output.
  always_ff @(posedge clk) begin
    if (pix_valid && !rst) begin
      r_lb2[w_col] <= w_lb1;
      r_lb1[w_col] <= pix_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col        <= '0;
      r_row        <= '0;
      r_win_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      for (int unsigned i = 0; i < 9; i++) begin
        r_win[i] <= '0;
        r_out[i] <= '0;
      end
    end else if (pix_valid) begin
      for (int unsigned i = 0; i < 9; i++) begin
        r_win[i] <= w_next[i];
      end
      if (w_win_ok) begin
        for (int unsigned i = 0; i < 9; i++) begin
          r_out[i] <= w_next[i];
        end
      end
      r_win_valid  <= w_win_ok;
      r_frame_done <= w_last;
      if (w_col == COL_LAST) begin
        r_col <= '0;
        r_row <= (w_row == ROW_LAST) ? '0 : w_row + ROW_W'(1);
      end else begin
        r_col <= w_col + COL_W'(1);
        r_row <= w_row;
      end
    end else begin
      r_win_valid  <= 1'b0;
      r_frame_done <= 1'b0;
    end
  end

  assign win0       = r_out[0];
  assign win1       = r_out[1];
  assign win2       = r_out[2];
  assign win3       = r_out[3];
  assign win4       = r_out[4];
  assign win5       = r_out[5];
  assign win6       = r_out[6];
  assign win7       = r_out[7];
  assign win8       = r_out[8];
  assign win_valid  = r_win_valid;
  assign frame_done = r_frame_done;

endmodule
